// File: rtl/prim_slicer_seq.sv
// Holds one InW-bit word and emits it as ceil(InW/OutW) OutW-bit beats, lowest slice first.
// Optional macro PRIM_SLICER_SEQ_BACK2BACK_EN allows loading the next word on the last-beat handshake.
module prim_slicer_seq #(
  parameter int InW    = 64,
  parameter int OutW   = 8,
  parameter int IndexW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [InW-1:0]    data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [OutW-1:0]   data_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic [IndexW-1:0] idx_o,
  input  logic              abort_i,
  output logic              busy_o
);

  localparam int NumBeats = (InW + OutW - 1) / OutW;
  localparam int HeldW    = NumBeats * OutW;
  localparam int SelW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [IndexW-1:0] LastIdx = IndexW'(NumBeats - 1);

  if (NumBeats > 2**IndexW) begin : g_idx_width_chk
    $error("prim_slicer_seq: NumBeats exceeds 2**IndexW");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IndexW-1:0]   idx_q, idx_d;
  logic [HeldW-1:0]    held_q, held_d;

  logic [NumBeats-1:0][OutW-1:0] slices;
  logic                          send;
  logic                          last_beat;
  logic                          accept;

  assign slices    = held_q;
  assign send      = (state_q == SEND);
  assign last_beat = send && (idx_q == LastIdx);

`ifdef PRIM_SLICER_SEQ_BACK2BACK_EN
  // Combinational ready_i -> ready_o path lets the next word load on the final beat.
  assign ready_o = !send || (last_beat && ready_i && !abort_i);
`else
  assign ready_o = !send;
`endif

  assign accept  = valid_i && ready_o;

  assign valid_o = send;
  assign busy_o  = send;
  assign last_o  = last_beat;
  assign idx_o   = idx_q;
  assign data_o  = send ? slices[idx_q[SelW-1:0]] : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          held_d  = HeldW'(data_i);
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort wins over advance/last; the beat on the wire still counts if ready_i is high.
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
          held_d  = '0;
        end else if (ready_i) begin
          if (last_beat) begin
            idx_d   = '0;
            state_d = IDLE;
`ifdef PRIM_SLICER_SEQ_BACK2BACK_EN
            if (accept) begin
              held_d  = HeldW'(data_i);
              state_d = SEND;
            end
`endif
          end else begin
            idx_d = idx_q + IndexW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      held_q  <= held_d;
    end
  end

endmodule

// File: tb/tb_prim_slicer_seq.sv
// Randomized bench for prim_slicer_seq: a 64/8 instance and a 20/8 instance checked against
// a reference that slices each word arithmetically.
module tb_prim_slicer_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;

  logic        v64, r64, a64;
  logic [63:0] d64;
  logic        rdy64, vo64, last64, busy64;
  logic [7:0]  do64;
  logic [3:0]  idx64;

  logic        v20, r20, a20;
  logic [19:0] d20;
  logic        rdy20, vo20, last20, busy20;
  logic [7:0]  do20;
  logic [3:0]  idx20;

  int vectors = 0;
  int errs    = 0;

  always #5 clk_i = ~clk_i;

  prim_slicer_seq #(.InW(64), .OutW(8), .IndexW(4)) u_dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(v64), .data_i(d64), .ready_o(rdy64),
    .valid_o(vo64), .data_o(do64), .last_o(last64), .ready_i(r64), .idx_o(idx64),
    .abort_i(a64), .busy_o(busy64)
  );

  prim_slicer_seq #(.InW(20), .OutW(8), .IndexW(4)) u_dut20 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(v20), .data_i(d20), .ready_o(rdy20),
    .valid_o(vo20), .data_o(do20), .last_o(last20), .ready_i(r20), .idx_o(idx20),
    .abort_i(a20), .busy_o(busy20)
  );

  function automatic logic [7:0] beat_of(input logic [63:0] w, input int k);
    return 8'((w >> (8 * k)) & 64'hFF);
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle64(input string tag);
    vectors++;
    if (vo64 !== 1'b0 || rdy64 !== 1'b1 || busy64 !== 1'b0 || idx64 !== 4'd0 ||
        last64 !== 1'b0 || do64 !== 8'h00) begin
      errs++;
      $display("FAIL %s: valid=%b ready=%b busy=%b idx=%0d last=%b data=%h, want 0 1 0 0 0 00",
               tag, vo64, rdy64, busy64, idx64, last64, do64);
    end
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready pattern 1,0,0,1 repeating.
  // abort_beat < 0 means no abort.
  task automatic xfer64(input logic [63:0] w, input int mode, input int abort_beat, input string tag);
    int k = 0;
    int cyc = 0;
    int pat = 0;
    bit r, ab;
    v64 = 1'b1; d64 = w; r64 = 1'b0;
    a64 = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    vectors++;
    if (rdy64 !== 1'b1) begin
      errs++;
      $display("FAIL %s accept: ready_o=%b want 1", tag, rdy64);
    end
    next_cycle();
    v64 = 1'b0; d64 = $urandom; a64 = 1'b0;
    while (k < 8 && cyc < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (pat % 4 == 0) || (pat % 4 == 3);
      endcase
      pat++;
      ab = (k == abort_beat);
      if (ab) r = 1'b1;
      r64 = r; a64 = ab;
      #1;
      vectors++;
      if (vo64 !== 1'b1 || do64 !== beat_of(w, k) || idx64 !== 4'(k) || last64 !== (k == 7) ||
          busy64 !== 1'b1) begin
        errs++;
        $display("FAIL %s beat%0d: valid=%b data=%h idx=%0d last=%b busy=%b, want 1 %h %0d %b 1",
                 tag, k, vo64, do64, idx64, last64, busy64, beat_of(w, k), k, (k == 7));
      end
      vectors++;
`ifdef PRIM_SLICER_SEQ_BACK2BACK_EN
      if (rdy64 !== (k == 7 && r && !ab)) begin
`else
      if (rdy64 !== 1'b0) begin
`endif
        errs++;
        $display("FAIL %s ready_in_send beat%0d: ready_o=%b", tag, k, rdy64);
      end
      next_cycle();
      cyc++;
      if (r) k++;
      if (ab) break;
    end
    r64 = 1'b0; a64 = 1'b0;
    vectors++;
    if (cyc >= 200) begin
      errs++;
      $display("FAIL %s timeout: beats=%0d want 8", tag, k);
    end
    if (abort_beat >= 0 && abort_beat < 8) begin
      vectors++;
      if (k !== abort_beat + 1) begin
        errs++;
        $display("FAIL %s abort_count: beats=%0d want %0d", tag, k, abort_beat + 1);
      end
    end
    check_idle64({tag, " after"});
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    v64 = 0; r64 = 0; a64 = 0; d64 = '0;
    v20 = 0; r20 = 0; a20 = 0; d20 = '0;
    #2;
    check_idle64("reset64");
    vectors++;
    if (vo20 !== 1'b0 || rdy20 !== 1'b1 || busy20 !== 1'b0 || idx20 !== 4'd0 || do20 !== 8'h00) begin
      errs++;
      $display("FAIL reset20: valid=%b ready=%b busy=%b idx=%0d data=%h", vo20, rdy20, busy20, idx20, do20);
    end
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    check_idle64("post_reset");
  endtask

  task automatic test_basic();
    xfer64(64'h0706050403020100, 0, -1, "basic");
  endtask

  task automatic test_partial();
    logic [19:0] w;
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 20'hABCDE : 20'($urandom);
      v20 = 1'b1; d20 = w; r20 = 1'b1;
      next_cycle();
      v20 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #1;
        vectors++;
        if (vo20 !== 1'b1 || do20 !== beat_of({44'd0, w}, k) || idx20 !== 4'(k) || last20 !== (k == 2)) begin
          errs++;
          $display("FAIL partial w=%h beat%0d: valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                   w, k, vo20, do20, idx20, last20, beat_of({44'd0, w}, k), k, (k == 2));
        end
        next_cycle();
      end
      vectors++;
      if (vo20 !== 1'b0 || rdy20 !== 1'b1) begin
        errs++;
        $display("FAIL partial_end: valid=%b ready=%b want 0 1", vo20, rdy20);
      end
      r20 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    xfer64({$urandom, $urandom}, 2, -1, "bp_pattern");
    xfer64({$urandom, $urandom}, 1, -1, "bp_random");
  endtask

  task automatic test_abort();
    xfer64({$urandom, $urandom}, 0, 2, "abort2");
    xfer64(64'h1122334455667788, 0, -1, "after_abort");
    xfer64({$urandom, $urandom}, 2, 7, "abort_last");
  endtask

  task automatic test_async_reset();
    logic [63:0] w = {$urandom, $urandom};
    v64 = 1'b1; d64 = w; r64 = 1'b1;
    next_cycle();
    v64 = 1'b0;
    for (int k = 0; k < 3; k++) next_cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle64("async_reset");
    r64 = 1'b0;
    next_cycle();
    #2;
    rst_ni = 1'b1;
    next_cycle();
    xfer64(w, 0, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      xfer64({$urandom, $urandom}, 1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, "random");
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1 = {$urandom, $urandom};
    logic [63:0] w2 = {$urandom, $urandom};
    int accepts = 0, bi = 0, gaps = 0, cyc = 0;
    int exp_gaps;
`ifdef PRIM_SLICER_SEQ_BACK2BACK_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    r64 = 1'b1; a64 = 1'b0;
    while (bi < 16 && cyc < 60) begin
      v64 = (accepts < 2);
      d64 = (accepts == 0) ? w1 : w2;
      #1;
      if (vo64) begin
        vectors++;
        if (do64 !== beat_of(bi < 8 ? w1 : w2, bi % 8) || idx64 !== 4'(bi % 8) || last64 !== (bi % 8 == 7)) begin
          errs++;
          $display("FAIL b2b beat%0d: data=%h idx=%0d last=%b, want %h %0d %b", bi, do64, idx64, last64,
                   beat_of(bi < 8 ? w1 : w2, bi % 8), bi % 8, (bi % 8 == 7));
        end
        bi++;
      end else if (bi > 0) begin
        gaps++;
      end
      if (v64 && rdy64) accepts++;
      next_cycle();
      cyc++;
    end
    v64 = 1'b0; r64 = 1'b0;
    vectors++;
    if (bi !== 16 || gaps !== exp_gaps) begin
      errs++;
      $display("FAIL b2b_stream: beats=%0d gaps=%0d, want 16 %0d", bi, gaps, exp_gaps);
    end
    #1;
    check_idle64("b2b_end");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/prim_slicer_seq.md
Name: prim_slicer_seq

Overview:
- Sequencer for the OutW-granularity slicing datapath. Accepts one InW-bit word per valid/ready handshake, holds it, and emits it as ceil(InW/OutW) OutW-bit beats, lowest slice first, on a valid/ready output stream.
- Owns the slice index counter and drives it out as idx_o.
- Fractional last beat is zero-filled in its upper bits.
- Sits between a wide producer (e.g. a key/digest register) and a narrow consumer (byte/word bus).

Parameters:
- InW, 64, input word width; must be >= 1.
- OutW, 8, output beat width; must be >= 1.
- IndexW, 4, slice index width.
- Derived localparam NumBeats = ceil(InW/OutW). Elaboration assertion: NumBeats <= 2**IndexW.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input word valid.
- data_i  input  InW  input word.
- ready_o  output  1  block can accept a word.
- valid_o  output  1  output beat valid.
- data_o  output  OutW  output beat.
- last_o  output  1  current beat is the final beat of the word.
- ready_i  input  1  consumer accepts beat.
- idx_o  output  IndexW  index of the current beat.
- abort_i  input  1  synchronous flush of the word in progress.
- busy_o  output  1  word held, beats outstanding.

Behaviour:
- Reset (async, rst_ni=0), asserted immediately and independent of clk_i:
  - state IDLE, idx 0, held word 0.
  - valid_o 0, last_o 0, data_o 0, idx_o 0, busy_o 0, ready_o 1.
  - Reset mid-word discards the word. valid_o drops without waiting for a clock.
- States: IDLE, SEND.
- In IDLE:
  - ready_o = 1, valid_o = 0.
  - valid_i && ready_o: register data_i zero-extended to NumBeats*OutW, idx <= 0, next state SEND.
- Input-to-output latency: word accepted at edge N; beat 0 valid in the cycle after N.
- In SEND:
  - ready_o = 0, valid_o = 1, busy_o = 1.
  - data_o = held[idx*OutW +: OutW]. last_o = (idx == NumBeats-1). idx_o = idx.
  - valid_o, data_o, idx_o and last_o stay stable until the beat handshake (valid_o && ready_i). valid_o never deasserts before that except on abort or reset.
- Beat handshake, not last: idx <= idx+1.
- Beat handshake, last: next state IDLE, idx <= 0. ready_o is 1 the following cycle, so there is one bubble per word.
- NumBeats == 1: a single beat with last_o = 1; otherwise identical.
- Zero fill: bits of the final beat above InW read 0. Held-word bits are never exposed beyond NumBeats.
- abort_i in SEND:
  - The beat presented that cycle counts as transferred if ready_i = 1.
  - Next state IDLE, idx 0, held word cleared to 0. No further beats.
  - abort_i has priority over the advance/last transitions.
- abort_i in IDLE: ignored. Input acceptance is not blocked that cycle.
- idx never exceeds NumBeats-1. No wrap occurs inside a word.
- All outputs are decoded from registered state; no combinational path from valid_i/data_i to outputs. The only exception is under the optional feature.

Optional Feature:
- Macro: PRIM_SLICER_SEQ_BACK2BACK_EN.
- Defined:
  - ready_o = IDLE || (SEND && last_o && ready_i && !abort_i). This is a combinational path from ready_i to ready_o.
  - Last-beat handshake plus valid_i in the same cycle: load new word, idx <= 0, stay in SEND. The new word's beat 0 appears the next cycle, giving zero bubble between words.
- Undefined: behaviour as above, with ready_o purely state-decoded and one idle cycle between words.

Test Plan:
- InW=64, OutW=8, ready_i=1, data_i=0x0706050403020100:
  - valid_o high for 8 consecutive cycles starting the cycle after accept.
  - data_o = 0x00..0x07; idx_o = 0..7; last_o only on 0x07.
  - ready_o = 1 the cycle after the last beat.
- InW=20, OutW=8, data_i=0xABCDE:
  - 3 beats: 0xDE, 0xBC, 0x0A (upper nibble zero-filled); last_o on the third.
- Backpressure: toggle ready_i 1,0,0,1 → data_o/idx_o held stable through the stalled cycles; no beat dropped or duplicated; ready_o stays 0 until the final handshake.
- Abort after beat 2 of 8 (ready_i=1 on the abort cycle):
  - Exactly 3 beats transferred, then valid_o = 0 and ready_o = 1 next cycle.
  - A new word sent afterward starts at idx_o = 0.
- rst_ni pulsed low mid-word (asynchronously, between edges) → valid_o, busy_o go 0 and ready_o goes 1 immediately; first word after release starts at beat 0.
- With PRIM_SLICER_SEQ_BACK2BACK_EN, two words streamed with valid_i and ready_i held at 1 → 16 contiguous valid beats with no gap; without the macro, exactly one idle cycle between beat 7 and the next beat 0.
